// File: rtl/alu_ctrl_pkg.sv
// ALU control code definitions shared by the decoder and encoder.
// Holds the 4-bit code type, the ten legal codes and the FIFO entry.
package alu_ctrl_pkg;

  typedef logic [3:0] alu_code_t;

  localparam alu_code_t ALU_ADD  = 4'b0000;
  localparam alu_code_t ALU_SUB  = 4'b0001;
  localparam alu_code_t ALU_SLL  = 4'b0010;
  localparam alu_code_t ALU_SLT  = 4'b0011;
  localparam alu_code_t ALU_SLTU = 4'b0100;
  localparam alu_code_t ALU_XOR  = 4'b0101;
  localparam alu_code_t ALU_SRL  = 4'b0110;
  localparam alu_code_t ALU_SRA  = 4'b0111;
  localparam alu_code_t ALU_OR   = 4'b1000;
  localparam alu_code_t ALU_AND  = 4'b1101;

  localparam alu_code_t ALU_ILLEGAL = 4'b0000;

  localparam int OP_W = 10;

  typedef struct packed {
    alu_code_t code;
    logic      err;
  } alu_entry_t;

endpackage

// File: rtl/alu_onehot_to_code.sv
// One-hot ALU select to 4-bit control code, with legality check.
// Only exactly-one-hot selects are legal; others map to ALU_ILLEGAL.
module alu_onehot_to_code
  import alu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] onehot,
  output alu_code_t       code,
  output logic            legal
);

  assign legal = ($countones(onehot) == 1);

  always_comb begin
    code = ALU_ILLEGAL;
    if (legal) begin
      unique case (1'b1)
        onehot[0]: code = ALU_ADD;
        onehot[1]: code = ALU_SUB;
        onehot[2]: code = ALU_SLL;
        onehot[3]: code = ALU_SLT;
        onehot[4]: code = ALU_SLTU;
        onehot[5]: code = ALU_XOR;
        onehot[6]: code = ALU_SRL;
        onehot[7]: code = ALU_SRA;
        onehot[8]: code = ALU_OR;
        onehot[9]: code = ALU_AND;
        default:   code = ALU_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_encoder.sv
// One-hot ALU select encoder with a 2-entry output FIFO.
// Optional error counter built with ALU_OP_ENCODER_ERRCNT_EN.
module alu_op_encoder
  import alu_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [OP_W-1:0] in_onehot,
  output logic            in_ready,
  output logic            out_valid,
  output alu_code_t       out_code,
  output logic            out_err,
  input  logic            out_ready
`ifdef ALU_OP_ENCODER_ERRCNT_EN
  ,
  input  logic            err_clr,
  output logic [CNT_W-1:0] err_count
`endif
);

  if (DEPTH != 2 || CNT_W < 1) begin : g_bad_cfg
    $error("alu_op_encoder: DEPTH must be 2, CNT_W >= 1");
  end

  alu_code_t  dec_code;
  logic       dec_legal;
  alu_entry_t new_e;

  alu_onehot_to_code u_dec (
    .onehot (in_onehot),
    .code   (dec_code),
    .legal  (dec_legal)
  );

  assign new_e = '{code: dec_code, err: ~dec_legal};

  alu_entry_t mem [2];
  alu_entry_t head_q;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_ready  = (count != 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_code  = head_q.code;
  assign out_err   = head_q.err;

  // head_q mirrors mem[rd_ptr] but holds its value once drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head_q <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_e;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && (count == 2'd0 ||
                   (pop && count == 2'd1)))
        head_q <= new_e;
      else if (pop && count == 2'd2)
        head_q <= mem[~rd_ptr];
    end
  end

`ifdef ALU_OP_ENCODER_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             ill_push;

  assign ill_push  = push & ~dec_legal;
  assign err_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= ill_push ? CNT_W'(1) : '0;
    end else if (ill_push && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_encoder.sv
// Scoreboard bench for alu_op_encoder: random and directed pushes
// checked against a popcount/index reference model.
module tb_alu_op_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [9:0] in_onehot;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_code;
  logic       out_err;
  logic       out_ready;
  logic       err_clr;
  logic [7:0] err_count;

  int vec = 0;
  int mis = 0;
  int pops = 0;
  int exp_cnt = 0;
  bit rnd_rdy = 0;

  typedef struct {
    logic [3:0] code;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

`ifdef ALU_OP_ENCODER_ERRCNT_EN
  alu_op_encoder #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_onehot(in_onehot),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_code(out_code), .out_err(out_err),
    .out_ready(out_ready),
    .err_clr(err_clr), .err_count(err_count)
  );
`else
  alu_op_encoder #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_onehot(in_onehot),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_code(out_code), .out_err(out_err),
    .out_ready(out_ready)
  );
  assign err_count = 8'd0;
`endif

  function automatic exp_t model(input logic [9:0] v);
    exp_t e;
    int n = 0;
    int idx = 0;
    for (int i = 0; i < 10; i++)
      if (v[i]) begin n++; idx = i; end
    if (n == 1) begin
      e.code = (idx <= 8) ? 4'(idx) : 4'd13;
      e.err  = 1'b0;
    end else begin
      e.code = 4'd0;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string nm,
                     input int act, input int req);
    vec++;
    if (act != req) begin
      mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // monitor: handshake seen here completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        vec++; mis++;
        $display("FAIL unexpected_out: got code %0d expected none",
                 out_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_code", int'(out_code), int'(e.code));
        chk("out_err", int'(out_err), int'(e.err));
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after acceptance
  task automatic send(input logic [9:0] v);
    bit done = 0;
    in_valid  = 1'b1;
    in_onehot = v;
    for (int t = 0; t < 100 && !done; t++) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e = model(v);
        exp_q.push_back(e);
        if (e.err)
          exp_cnt = err_clr ? 1 : (exp_cnt < 255 ? exp_cnt + 1 : 255);
        else if (err_clr)
          exp_cnt = 0;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    bit ok = 0;
    in_valid  = 1'b0;
    rnd_rdy   = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) ok = 1;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 10'b0000000100;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_code", int'(out_code), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_err_count", int'(err_count), 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    send(10'b0000000100);
    in_valid = 1'b0;
    chk("first_valid", int'(out_valid), 1);
    chk("first_code", int'(out_code), 2);
    out_ready = 1'b1;
    idle(2);

    p0 = pops;
    for (int i = 0; i < 10; i++) send(10'(1 << i));
    idle(2);
    chk("sweep_thru", pops - p0, 10);

    send(10'b0);
    send(10'b0000000011);
    idle(3);
`ifdef ALU_OP_ENCODER_ERRCNT_EN
    chk("err_count_2", int'(err_count), 2);
`endif

    out_ready = 1'b0;
    send(10'b0000010000);
    send(10'b1000000000);
    in_valid = 1'b0;
    chk("bp_full_ready", int'(in_ready), 0);
    in_valid  = 1'b1;
    in_onehot = 10'b0100000000;
    repeat (2) begin @(posedge clk); #1; end
    chk("bp_held_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", int'(in_ready), 1);
    send(10'b0100000000);
    drain();

    out_ready = 1'b0;
    send(10'b0000001000);
    out_ready = 1'b1;
    send(10'b0000100000);
    in_valid = 1'b0;
    chk("pp_valid", int'(out_valid), 1);
    chk("pp_ready", int'(in_ready), 1);
    drain();

`ifdef ALU_OP_ENCODER_ERRCNT_EN
    err_clr = 1'b1;
    send(10'b1100000000);
    err_clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_with_ill", int'(err_count), 1);
    for (int i = 0; i < 256; i++) send(10'b0);
    in_valid = 1'b0;
    chk("sat_model", exp_cnt, 255);
    chk("err_sat", int'(err_count), 255);
    drain();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    exp_cnt = 0;
    chk("err_clr_only", int'(err_count), 0);
`endif

    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      logic [9:0] v;
      if ($urandom_range(0, 9) < 7)
        v = 10'(1 << $urandom_range(0, 9));
      else
        v = 10'($urandom);
      send(v);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();
`ifdef ALU_OP_ENCODER_ERRCNT_EN
    chk("rnd_err_count", int'(err_count), exp_cnt);
`endif

    out_ready = 1'b0;
    send(10'b0000000010);
    send(10'b0000000000);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_in_ready", int'(in_ready), 1);
    chk("mrst_out_code", int'(out_code), 0);
    chk("mrst_out_err", int'(out_err), 0);
    chk("mrst_err_count", int'(err_count), 0);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(3);
    chk("mrst_no_stale", int'(out_valid), 0);
    send(10'b0010000000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/alu_op_encoder.md
# alu_op_encoder

Converts a 10-bit one-hot ALU operation select back into the 4-bit ALU control code used on the execute-stage control bus. It is the inverse of the ALU control decoder and sits between the issue logic, which produces one-hot operation selects, and the control-signal pipeline register. The block buffers codes in a 2-entry queue behind a valid/ready handshake. It flags any input that is not strictly one-hot, and can optionally count those errors.

## Interface
Parameters:
- DEPTH, 2, output queue depth in entries; only 2 is supported.
- CNT_W, 8, width of the error counter.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset; asynchronous assert, active-low.
- in_valid, input, 1, a one-hot select is presented this cycle.
- in_onehot, input, 10, one-hot operation select.
- in_ready, output, 1, the queue can accept an entry.
- out_valid, output, 1, the head entry is valid.
- out_code, output, 4, ALU control code of the head entry.
- out_err, output, 1, the head entry came from an illegal input.
- out_ready, input, 1, the consumer accepts the head entry.
- err_clr, input, 1, clears err_count (built only with the macro).
- err_count, output, CNT_W, saturating count of illegal inputs accepted (built only with the macro).

## Operation
Code mapping for in_onehot (the only legal inputs):
- Bits 0 to 7 map to codes 4'b0000 to 4'b0111 respectively.
- Bit 8 maps to 4'b1000.
- Bit 9 maps to 4'b1101.

Illegal inputs:
- An all-zero or multi-hot in_onehot is illegal.
- An illegal input produces code 4'b0000 with out_err = 1.
- Codes 4'b1001 to 4'b1100 and 4'b1110 to 4'b1111 are never produced.

Queue behaviour:
- Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
- The queue is a 2-entry FIFO with a 2-bit occupancy count (0 to 2).
- in_ready = (count != 2). It is registered-state derived, with no combinational path from out_ready.
- out_valid = (count != 0). out_code and out_err show the head entry.
- Push and pop in the same cycle: count is unchanged, the head advances, and the new entry is written behind it.
- At count = 2, in_ready = 0 even if out_ready = 1 (no pass-through).
- Pointers wrap modulo 2.
- When out_valid = 0, out_code and out_err hold their last values; the consumer must ignore them.
- in_onehot must stay stable while in_valid && !in_ready. A change is not checked and is undefined.

Reset:
- On rst_n low, count, pointers, out_code, out_err and err_count are cleared immediately.
- The result is out_valid = 0, in_ready = 1, out_code = 0, out_err = 0, err_count = 0.
- A handshake in flight when reset asserts is discarded.

## Timing
- Latency from push at edge N to out_valid high is 1 cycle: out_valid rises after edge N when the queue was empty.
- Sustained throughput is 1 entry per cycle while out_ready is held high.
- in_ready reasserts the cycle after a pop from the full state.
- err_count updates on the edge of the push that carries an illegal input.

## Configuration
The only macro is ALU_OP_ENCODER_ERRCNT_EN.

Defined:
- err_clr and err_count exist.
- The counter increments by 1 per accepted illegal input and saturates at 2^CNT_W - 1.
- When err_clr and an illegal push occur in the same cycle, the result is 1.
- err_clr alone sets the counter to 0.

Undefined:
- Neither port nor the counter exists.
- out_err behaviour is unchanged.

## Structure
- Shared package alu_ctrl_pkg holds:
  - a typedef for the 4-bit ALU control code;
  - named constants for the ten legal codes;
  - the illegal-input default code (4'b0000).
- The decoder and this encoder both import the package.
- One combinational sub-module, alu_onehot_to_code, holds the mapping and the legality check: popcount == 1.
- The top level holds the FIFO, the handshake and the counter.

## Test plan
- Reset: hold rst_n low with in_valid = 1 -> out_valid = 0, in_ready = 1, out_code = 0, err_count = 0. Release -> first push 10'b0000000100 gives out_code = 4'b0010 one cycle later.
- Full sweep: push each of the ten one-hot values back to back with out_ready = 1 -> codes 0 to 8 then 4'b1101 in order, out_err = 0 throughout, one result per cycle.
- Illegal inputs: push 10'b0 then 10'b0000000011 -> two entries with out_code = 4'b0000 and out_err = 1. With the macro defined, err_count = 2.
- Backpressure: hold out_ready = 0 and push 3 inputs -> in_ready drops after 2 accepted and the third is held. Raise out_ready -> all three drain in order, with in_ready high one cycle after the first pop.
- Simultaneous events:
  - At count = 1, push and pop together -> count stays 1 and order is preserved.
  - err_clr together with an illegal push -> err_count = 1.
  - With CNT_W = 8 and 256 illegal pushes -> err_count saturates at 255.
- Mid-operation reset: drop rst_n with 2 entries queued -> outputs clear immediately, and no stale entry appears after release.
